// File: rtl/vx_kernel_launcher.sv
// Launch sequencer for one Vortex socket: replays a staged DCR table under reset,
// releases the socket, then watches busy to report done, an error code and run cycles.
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

module vx_kernel_launcher #(
   parameter int NUM_DCRS       = 8,
   parameter int DCR_ADDR_WIDTH = `VX_DCR_ADDR_WIDTH,
   parameter int DCR_DATA_WIDTH = `VX_DCR_DATA_WIDTH,
   parameter int START_WAIT     = 64,
   parameter int TIMEOUT        = 0,
   parameter int CYCLE_WIDTH    = 32,
   localparam int IDX_W         = (NUM_DCRS > 1) ? $clog2(NUM_DCRS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_valid,
   input  logic [IDX_W-1:0]          cfg_idx,
   input  logic [DCR_ADDR_WIDTH-1:0] cfg_addr,
   input  logic [DCR_DATA_WIDTH-1:0] cfg_data,
   input  logic                      cfg_clear,
   output logic                      cfg_ready,
   input  logic                      launch_valid,
   output logic                      launch_ready,
   input  logic                      abort,
   output logic                      write_valid,
   output logic [DCR_ADDR_WIDTH-1:0] write_addr,
   output logic [DCR_DATA_WIDTH-1:0] write_data,
   output logic                      core_reset,
   input  logic                      busy,
   output logic                      done,
   output logic [1:0]                err,
   output logic [CYCLE_WIDTH-1:0]    cycles
);

   localparam int TBL_SZ = 2 ** IDX_W;
   localparam int WAIT_W = $clog2(START_WAIT + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DCRS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_WAIT - 1);

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_NOSTART = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WRITE, ST_RELEASE, ST_WAIT_BUSY, ST_RUN, ST_DONE
   } state_e;

   typedef struct packed {
      logic                      en;
      logic [DCR_ADDR_WIDTH-1:0] addr;
      logic [DCR_DATA_WIDTH-1:0] data;
   } entry_t;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [WAIT_W-1:0]         wait_q, wait_d;
   logic [CYCLE_WIDTH-1:0]    cycles_q, cycles_d, cyc_inc;
   logic [1:0]                err_q, err_d;
   entry_t                    tbl_q [TBL_SZ];
   entry_t                    tbl_d [TBL_SZ];
   logic                      write_valid_q, write_valid_d;
   logic [DCR_ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
   logic [DCR_DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic                      core_reset_q, core_reset_d;
   logic                      done_q, done_d;
   logic                      wr_en;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      cycles_d = cycles_q;
      err_d    = err_q;
      tbl_d    = tbl_q;
      cyc_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            // clear first so a same-cycle write survives it
            if (cfg_clear)
               for (int i = 0; i < TBL_SZ; i++) tbl_d[i].en = 1'b0;
            if (cfg_valid)
               tbl_d[cfg_idx] = '{en: 1'b1, addr: cfg_addr, data: cfg_data};
            if (launch_valid) begin
               state_d  = ST_WRITE;
               idx_d    = '0;
               cycles_d = '0;
               err_d    = ERR_OK;
            end
         end
         ST_WRITE: begin
            if (idx_q == LAST_IDX) state_d = ST_RELEASE;
            else                   idx_d   = idx_q + 1'b1;
         end
         ST_RELEASE: begin
            state_d = ST_WAIT_BUSY;
            wait_d  = '0;
         end
         ST_WAIT_BUSY: begin
            if (busy) begin
               state_d = ST_RUN;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_DONE;
               err_d   = ERR_NOSTART;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_RUN: begin
            cycles_d = cyc_inc;
            if (TIMEOUT != 0 && 64'(cyc_inc) == 64'(TIMEOUT)) begin
               state_d = ST_DONE;
               err_d   = ERR_TIMEOUT;
            end else if (!busy) begin
               state_d = ST_DONE;
               err_d   = ERR_OK;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (abort && (state_q inside {ST_WRITE, ST_RELEASE, ST_WAIT_BUSY, ST_RUN})) begin
         state_d = ST_DONE;
         err_d   = ERR_ABORT;
      end

      // outputs are registered, so decode them from the next state
      wr_en         = (state_d == ST_WRITE) && tbl_d[idx_d].en;
      write_valid_d = wr_en;
      write_addr_d  = wr_en ? tbl_d[idx_d].addr : '0;
      write_data_d  = wr_en ? tbl_d[idx_d].data : '0;
      core_reset_d  = !(state_d inside {ST_RELEASE, ST_WAIT_BUSY, ST_RUN});
      done_d        = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         wait_q        <= '0;
         cycles_q      <= '0;
         err_q         <= ERR_OK;
         tbl_q         <= '{default: '0};
         write_valid_q <= 1'b0;
         write_addr_q  <= '0;
         write_data_q  <= '0;
         core_reset_q  <= 1'b1;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         wait_q        <= wait_d;
         cycles_q      <= cycles_d;
         err_q         <= err_d;
         tbl_q         <= tbl_d;
         write_valid_q <= write_valid_d;
         write_addr_q  <= write_addr_d;
         write_data_q  <= write_data_d;
         core_reset_q  <= core_reset_d;
         done_q        <= done_d;
      end
   end

   assign cfg_ready    = (state_q == ST_IDLE);
   assign launch_ready = (state_q == ST_IDLE);
   assign write_valid  = write_valid_q;
   assign write_addr   = write_addr_q;
   assign write_data   = write_data_q;
   assign core_reset   = core_reset_q;
   assign done         = done_q;
   assign err          = err_q;
   assign cycles       = cycles_q;

endmodule

// File: tb/tb_vx_kernel_launcher.sv
// Bench for vx_kernel_launcher: directed and random launches against a timeline model
// that predicts writes, reset window, done cycle, error code and run cycles.
module tb_vx_kernel_launcher;

   localparam int N   = 4;
   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int SW  = 64;
   localparam int TO  = 100;
   localparam int CW  = 32;
   localparam int W   = N + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_valid = 1'b0;
   logic [1:0]    cfg_idx = '0;
   logic [AW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_data = '0;
   logic          cfg_clear = 1'b0;
   logic          cfg_ready;
   logic          launch_valid = 1'b0;
   logic          launch_ready;
   logic          abort = 1'b0;
   logic          write_valid;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] write_data;
   logic          core_reset;
   logic          busy = 1'b0;
   logic          done;
   logic [1:0]    err;
   logic [CW-1:0] cycles;

   vx_kernel_launcher #(
      .NUM_DCRS(N), .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW),
      .START_WAIT(SW), .TIMEOUT(TO), .CYCLE_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_clear(cfg_clear), .cfg_ready(cfg_ready),
      .launch_valid(launch_valid), .launch_ready(launch_ready), .abort(abort),
      .write_valid(write_valid), .write_addr(write_addr), .write_data(write_data),
      .core_reset(core_reset), .busy(busy), .done(done), .err(err), .cycles(cycles)
   );

   always #5 clk = ~clk;

   typedef struct {int k; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

   int passed = 0;
   int total  = 0;

   // reference table
   bit            m_en   [N];
   logic [AW-1:0] m_addr [N];
   logic [DW-1:0] m_data [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
   endtask

   task automatic cfg(input bit vld, input bit clr, input int idx,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
      cfg_valid = vld; cfg_clear = clr; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
      @(posedge clk); @(negedge clk);
      cfg_valid = 1'b0; cfg_clear = 1'b0;
      if (clr) for (int i = 0; i < N; i++) m_en[i] = 1'b0;
      if (vld) begin m_en[idx] = 1'b1; m_addr[idx] = a; m_data[idx] = d; end
   endtask

   // busy rises d cycles after the first WAIT_BUSY cycle and stays high L cycles;
   // d >= SW means it never rises. A>0: abort at cycle A. cfg_at/rst_at: disturbance cycles.
   task automatic launch(input string tag, input int d, input int L, input int A,
                         input int cfg_at, input int rst_at);
      wr_t exp_wr[$];
      wr_t got_wr[$];
      wr_t w;
      bit  started = (d < SW);
      int  run, exp_done, exp_err, exp_cyc, exp_low;
      int  done_k = -1, first_low = -1, lowcnt = 0, zero_bad = 0, n_done = 0;
      logic [1:0]    got_err = '0;
      logic [CW-1:0] got_cyc = '0;
      bit  finished = 1'b0;

      for (int s = 1; s <= N; s++)
         if (m_en[s-1] && (A == 0 || s <= A)) begin
            w.k = s; w.a = m_addr[s-1]; w.d = m_data[s-1]; exp_wr.push_back(w);
         end
      run = (L < TO) ? L : TO;
      if (A > 0)         begin exp_done = A + 1;           exp_err = 3;               exp_cyc = 0;   end
      else if (!started) begin exp_done = W + SW;          exp_err = 1;               exp_cyc = 0;   end
      else               begin exp_done = W + d + run + 1; exp_err = (L >= TO) ? 2 : 0; exp_cyc = run; end
      exp_low = (rst_at > 0) ? rst_at - N : ((exp_done > N + 1) ? exp_done - (N + 1) : 0);

      launch_valid = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); @(negedge clk);
         launch_valid = 1'b0;
         if (write_valid) begin
            w.k = k; w.a = write_addr; w.d = write_data; got_wr.push_back(w);
         end else if (write_addr != '0 || write_data != '0) zero_bad++;
         if (!core_reset) begin
            lowcnt++;
            if (first_low < 0) first_low = k;
         end
         if (done) begin
            n_done++;
            if (done_k < 0) begin done_k = k; got_err = err; got_cyc = cycles; end
         end
         if (rst_at > 0 && k == rst_at + 1) begin
            reset = 1'b0;
            chk({tag, ".rst_core_reset"}, 64'(core_reset), 64'd1);
            chk({tag, ".rst_cycles"}, 64'(cycles), 64'd0);
            chk({tag, ".rst_idle"}, 64'(launch_ready), 64'd1);
            for (int i = 0; i < N; i++) m_en[i] = 1'b0;
            finished = 1'b1;
            break;
         end
         if (done_k > 0 && k == done_k + 1) begin
            chk({tag, ".done_width"}, 64'(n_done), 64'd1);
            chk({tag, ".ready_after"}, 64'(launch_ready), 64'd1);
            chk({tag, ".err_hold"}, 64'(err), 64'(exp_err));
            finished = 1'b1;
            break;
         end
         busy      = started && (k >= W + d) && (k < W + d + L);
         abort     = (k == A);
         reset     = (k == rst_at);
         cfg_valid = (k == cfg_at);
         cfg_clear = (k == cfg_at);
         cfg_idx   = '0; cfg_addr = 12'h3ff; cfg_data = 32'h0000dead;
      end
      busy = 1'b0; abort = 1'b0; reset = 1'b0; cfg_valid = 1'b0; cfg_clear = 1'b0;

      chk({tag, ".finished"}, 64'(finished), 64'd1);
      chk({tag, ".nwrites"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
         chk($sformatf("%s.wr%0d_slot", tag, i), 64'(got_wr[i].k), 64'(exp_wr[i].k));
         chk($sformatf("%s.wr%0d_addr", tag, i), 64'(got_wr[i].a), 64'(exp_wr[i].a));
         chk($sformatf("%s.wr%0d_data", tag, i), 64'(got_wr[i].d), 64'(exp_wr[i].d));
      end
      chk({tag, ".idle_addr_data_zero"}, 64'(zero_bad), 64'd0);
      chk({tag, ".first_release"}, 64'(first_low), 64'((exp_low > 0) ? N + 1 : -1));
      chk({tag, ".release_len"}, 64'(lowcnt), 64'(exp_low));
      if (rst_at > 0) begin
         chk({tag, ".no_done"}, 64'(done_k), 64'(-1));
      end else begin
         chk({tag, ".done_cycle"}, 64'(done_k), 64'(exp_done));
         chk({tag, ".err"}, 64'(got_err), 64'(exp_err));
         chk({tag, ".cycles"}, 64'(got_cyc), 64'(exp_cyc));
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin m_en[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; end

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset.core_reset", 64'(core_reset), 64'd1);
      chk("reset.write_valid", 64'(write_valid), 64'd0);
      chk("reset.write_addr", 64'(write_addr), 64'd0);
      chk("reset.write_data", 64'(write_data), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.err", 64'(err), 64'd0);
      chk("reset.cycles", 64'(cycles), 64'd0);
      chk("reset.cfg_ready", 64'(cfg_ready), 64'd1);
      chk("reset.launch_ready", 64'(launch_ready), 64'd1);

      cfg(1, 0, 0, 12'h001, 32'h8000_0000);
      cfg(1, 0, 1, 12'h002, 32'h0000_0001);
      launch("basic", 0, 10, 0, 0, 0);
      launch("nostart", SW, 0, 0, 0, 0);
      launch("timeout", 0, 200, 0, 0, 0);
      launch("to_edge", 3, TO, 0, 0, 0);
      launch("to_minus1", 5, TO - 1, 0, 0, 0);
      launch("late_start", SW - 1, 7, 0, 0, 0);
      launch("abort_wr2", 0, 10, 2, 0, 0);
      launch("abort_wait", 0, 10, W, 0, 0);

      // table writes while running are ignored
      launch("cfg_in_run", 0, 20, 0, W + 5, 0);
      launch("cfg_replay", 0, 5, 0, 0, 0);
      cfg(1, 1, 2, 12'h0a5, 32'h1234_5678);
      launch("clear_write", 0, 4, 0, 0, 0);

      launch("rst_mid_run", 0, 50, 0, 0, W + 10);
      launch("after_rst", 0, 10, N + 1, 0, 0);

      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 3) == 0) cfg(0, 1, 0, '0, '0);
         for (int j = 0, nw = $urandom_range(1, 3); j < nw; j++)
            cfg(1, 0, $urandom_range(0, N - 1), AW'($urandom), $urandom);
         launch($sformatf("rand%0d", it), $urandom_range(0, 70), $urandom_range(1, 110),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0, 0, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
